// File: rtl/tt_um_inverter_arbiter.sv
// Tiny Tapeout tile: four requesters share one registered inverting output lane.
// A round-robin arbiter grants one requester, whose byte is captured, inverted and held.
module tt_um_inverter_arbiter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] ptr;
  logic [1:0] gnt_idx;
  logic [1:0] sel_idx;
  logic [1:0] cand;
  logic [3:0] gnt;
  logic [3:0] req;
  logic [7:0] data;
  logic [7:0] cnt;

  assign req = uio_in[3:0];

  // Scan from the farthest candidate down so the nearest one after ptr wins.
  always_comb begin
    sel_idx = ptr + 2'd1;
    cand    = ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        sel_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd3;
      gnt_idx <= 2'd0;
      gnt     <= 4'b0000;
      data    <= 8'h00;
      cnt     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_idx <= sel_idx;
            gnt     <= 4'b0001 << sel_idx;
            state   <= GRANT;
          end
        end
        GRANT: begin
          gnt <= 4'b0000;
          // A request withdrawn during its grant aborts without moving the pointer.
          if (req[gnt_idx]) begin
            data  <= ~ui_in;
            ptr   <= gnt_idx;
            cnt   <= HOLD_LOAD;
            state <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (cnt == 8'h00) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'h01;
          end
        end
        default: begin
          gnt   <= 4'b0000;
          state <= IDLE;
        end
      endcase
    end
  end

  assign uo_out  = data;
  assign uio_out = {gnt, 4'b0000};
  assign uio_oe  = 8'hF0;

  wire unused_bits = &{1'b0, ena, uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_inverter_arbiter.sv
// Self-checking bench for tt_um_inverter_arbiter: a timestamp-based reference model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_tt_um_inverter_arbiter;

  localparam int HOLD = 4;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int checks_total;
  int checks_passed;
  int tick;

  // Reference model: who is granted and when the lane frees up, as cycle timestamps.
  int         cyc;
  int         free_at;
  int         grant_at;
  int         m_ptr;
  int         m_g;
  logic [7:0] exp_uo;
  logic [3:0] exp_gnt;

  tt_um_inverter_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s actual=%h expected=%h tick=%0d", name, act, exp, tick);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("[TB] FAIL %s actual=%0d expected=%0d tick=%0d", name, act, exp, tick);
  endtask

  task automatic model_update();
    if (!rst_n) begin
      exp_uo   = 8'h00;
      exp_gnt  = 4'h0;
      m_ptr    = 3;
      free_at  = 0;
      grant_at = -1;
      cyc      = 0;
    end else begin
      if (cyc == grant_at) begin
        if (uio_in[m_g]) begin
          exp_uo  = ~ui_in;
          m_ptr   = m_g;
          free_at = cyc + 1 + HOLD;
        end else begin
          free_at = cyc + 1;
        end
        exp_gnt = 4'h0;
      end else if (cyc >= free_at && uio_in[3:0] != 4'h0) begin
        for (int k = 4; k >= 1; k--) begin
          if (uio_in[(m_ptr + k) % 4]) m_g = (m_ptr + k) % 4;
        end
        grant_at = cyc + 1;
        exp_gnt  = 4'(1 << m_g);
      end else begin
        exp_gnt = 4'h0;
      end
      cyc++;
    end
  endtask

  task automatic check_output();
    check8("model_uo_out", uo_out, exp_uo);
    check8("model_uio_out", uio_out, {exp_gnt, 4'b0000});
    check8("uio_oe", uio_oe, 8'hF0);
  endtask

  task automatic tick_clock();
    @(posedge clk);
    model_update();
    tick++;
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic [7:0] req, input logic [7:0] data);
    uio_in = req;
    ui_in  = data;
  endtask

  task automatic wait_grant(input int max, output int waited);
    waited = 0;
    do begin
      tick_clock();
      waited++;
    end while (uio_out[7:4] == 4'h0 && waited < max);
    if (uio_out[7:4] == 4'h0) begin
      checks_total++;
      $display("[TB] FAIL grant_timeout actual=none expected=grant within %0d cycles", max);
    end
  endtask

  task automatic do_reset();
    apply_stimulus(8'($urandom), 8'($urandom));
    rst_n = 1'b0;
    repeat (3) tick_clock();
    check8("reset_uo_out", uo_out, 8'h00);
    check8("reset_uio_out", uio_out, 8'h00);
    check8("reset_uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    apply_stimulus(8'h00, 8'($urandom));
  endtask

  // Grant must always be one-hot or zero with the low bits tied off.
  always @(negedge clk) begin
    checks_total++;
    assert ($onehot0(uio_out[7:4]) && uio_out[3:0] == 4'h0) checks_passed++;
    else $display("[TB] FAIL grant_onehot actual=%h expected=one-hot or zero", uio_out);
  end

  logic [7:0] rr_ui  [4];
  logic [7:0] rr_gnt [5];
  logic [7:0] rr_uo  [5];

  initial begin
    int n;
    int last_tick;
    logic [7:0] r;
    checks_total  = 0;
    checks_passed = 0;
    tick          = 0;
    ena           = 1'b1;
    rst_n         = 1'b1;
    apply_stimulus(8'h00, 8'h00);
    rr_ui  = '{8'h00, 8'hFF, 8'hA5, 8'h0F};
    rr_gnt = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h10};
    rr_uo  = '{8'hFF, 8'h00, 8'h5A, 8'hF0, 8'hFF};
    #2;
    do_reset();

    // Idle with no requests: never a grant.
    repeat (3) begin
      tick_clock();
      check8("idle_no_grant", uio_out, 8'h00);
    end

    // Single request from req2.
    apply_stimulus(8'h04, 8'h00);
    wait_grant(10, n);
    check_int("single_grant_latency", n, 1);
    check8("single_grant", uio_out, 8'h40);
    apply_stimulus(8'h04, 8'h3C);
    tick_clock();
    check8("single_capture", uo_out, 8'hC3);
    check8("single_grant_drop", uio_out, 8'h00);
    wait_grant(20, n);
    check_int("single_regrant_gap", n, HOLD + 1);
    apply_stimulus(8'h00, 8'h99);
    tick_clock();

    // Round robin with all requests held.
    do_reset();
    apply_stimulus(8'h0F, 8'h00);
    last_tick = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(20, n);
      check8("rr_grant", uio_out, rr_gnt[i]);
      if (i > 0) check_int("rr_spacing", tick - last_tick, HOLD + 2);
      last_tick = tick;
      apply_stimulus(8'h0F, rr_ui[i % 4]);
      tick_clock();
      check8("rr_capture", uo_out, rr_uo[i]);
    end

    // Abort: req1 withdrawn during its grant.
    do_reset();
    apply_stimulus(8'h02, 8'h00);
    wait_grant(10, n);
    check8("abort_grant", uio_out, 8'h20);
    apply_stimulus(8'h00, 8'h77);
    tick_clock();
    check8("abort_uo_kept", uo_out, 8'h00);
    check8("abort_no_grant", uio_out, 8'h00);
    apply_stimulus(8'h0A, 8'h55);
    tick_clock();
    check8("abort_ptr_kept", uio_out, 8'h20);
    tick_clock();
    check8("abort_then_capture", uo_out, 8'hAA);

    // Inputs churn during HOLD but nothing changes.
    for (int i = 0; i < HOLD; i++) begin
      apply_stimulus(8'($urandom), 8'($urandom));
      tick_clock();
      check8("hold_uo_stable", uo_out, 8'hAA);
      check8("hold_no_grant", uio_out, 8'h00);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r[3:0] = 4'h0;
      apply_stimulus(r, 8'($urandom));
      tick_clock();
    end

    // Asynchronous reset in the middle of HOLD.
    apply_stimulus(8'h0F, 8'h12);
    wait_grant(20, n);
    tick_clock();
    check8("pre_reset_capture", uo_out, 8'hED);
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_reset_uo", uo_out, 8'h00);
    check8("async_reset_uio", uio_out, 8'h00);
    tick_clock();
    tick_clock();
    rst_n = 1'b1;
    apply_stimulus(8'h0F, 8'h00);
    wait_grant(10, n);
    check8("post_reset_grant", uio_out, 8'h10);
    tick_clock();

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
